// File: rtl/load_rdata_unit.sv
// Load-side data-memory reader: issues a word-aligned read, then aligns and extends the returned byte/half/word.
// Latency: handshake at edge T -> mem_rreq in T+1; rvalid in T+k -> wb_valid in T+k+1 (best case 2 cycles).
// Backpressure: req_ready_o only in IDLE; stall_o high in WAIT/DRAIN; request errors stay in IDLE (one per cycle).
// Optional feature: define LSU_TIMEOUT_EN to build the WAIT/DRAIN timeout counter (limit MAX_WAIT).
module load_rdata_unit #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        mem_rreq_o,
  output logic [31:0] mem_raddr_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic        stall_o
);

  // The timeout counter needs at least a one-bit range to be meaningful.
  if (MAX_WAIT < 2) begin : g_bad_max_wait
    $error("load_rdata_unit: MAX_WAIT must be >= 2");
  end

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
`ifdef LSU_TIMEOUT_EN
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;
  localparam int         CW             = $clog2(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST    = CW'(MAX_WAIT - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        mem_rreq_q;
  logic [31:0] mem_raddr_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        err_q;
  logic [1:0]  err_cause_q;
`ifdef LSU_TIMEOUT_EN
  logic [CW-1:0] cnt_q;
`endif

  logic        handshake;
  logic        req_illegal;
  logic        req_misalign;
  logic [31:0] rdata_sh;
  logic [31:0] ext_d;

  assign req_ready_o = (state_q == S_IDLE);
  assign stall_o     = (state_q != S_IDLE);
  assign handshake   = req_valid_i & req_ready_o;

  // Decode the incoming request for error conditions; illegal takes precedence at use site.
  always_comb begin
    req_illegal  = 1'b0;
    req_misalign = 1'b0;
    unique case (req_funct3_i)
      F3_LB, F3_LBU: req_misalign = 1'b0;
      F3_LH, F3_LHU: req_misalign = req_addr_i[0];
      F3_LW:         req_misalign = (req_addr_i[1:0] != 2'b00);
      default:       req_illegal  = 1'b1;
    endcase
  end

  // Align the addressed lane to bit 0 and extend according to the latched load type.
  assign rdata_sh = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ext_d = mem_rdata_i;
    unique case (funct3_q)
      F3_LB:   ext_d = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      F3_LBU:  ext_d = {24'h0, rdata_sh[7:0]};
      F3_LH:   ext_d = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      F3_LHU:  ext_d = {16'h0, rdata_sh[15:0]};
      default: ext_d = mem_rdata_i;
    endcase
  end

  // Main FSM with registered strobes; pulses default low every cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_IDLE;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      rd_q        <= 5'd0;
      mem_rreq_q  <= 1'b0;
      mem_raddr_q <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0;
      err_q       <= 1'b0;
      err_cause_q <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      mem_rreq_q <= 1'b0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (handshake) begin
            off_q    <= req_addr_i[1:0];
            funct3_q <= req_funct3_i;
            rd_q     <= req_rd_i;
            if (req_illegal) begin
              err_q       <= 1'b1;
              err_cause_q <= CAUSE_ILLEGAL;
            end else if (req_misalign) begin
              err_q       <= 1'b1;
              err_cause_q <= CAUSE_MISALIGN;
            end else begin
              state_q     <= S_WAIT;
              mem_rreq_q  <= 1'b1;
              mem_raddr_q <= {req_addr_i[31:2], 2'b00};
`ifdef LSU_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            state_q <= S_IDLE;
            if (!flush_i) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= ext_d;
              wb_rd_q    <= rd_q;
            end
          end else if (flush_i) begin
            state_q <= S_DRAIN;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_q     <= S_IDLE;
            err_q       <= 1'b1;
            err_cause_q <= CAUSE_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        S_DRAIN: begin
          if (mem_rvalid_i) begin
            state_q <= S_IDLE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CNT_LAST) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_rreq_o  = mem_rreq_q;
  assign mem_raddr_o = mem_raddr_q;
  assign wb_valid_o  = wb_valid_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_data_o   = wb_data_q;
  assign err_o       = err_q;
  assign err_cause_o = err_cause_q;

endmodule

// File: tb/tb_load_rdata_unit.sv
// Bench for load_rdata_unit: scoreboard of expected writebacks and error causes checked by a monitor.
// Inputs change #1 after the rising edge; the monitor samples on the falling edge.
// Memory latency is driven explicitly by each scenario task.
module tb_load_rdata_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic        flush;
  logic        mem_rreq;
  logic [31:0] mem_raddr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;
  logic [1:0]  err_cause;
  logic        stall;

  int checks = 0;
  int errors = 0;

  logic [36:0] exp_wb[$];
  logic [1:0]  exp_err[$];

  localparam logic [31:0] RDATA = 32'h80FF_7F01;

  load_rdata_unit #(.MAX_WAIT(4)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_funct3_i(req_funct3), .req_rd_i(req_rd),
    .flush_i(flush),
    .mem_rreq_o(mem_rreq), .mem_raddr_o(mem_raddr),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .err_o(err), .err_cause_o(err_cause), .stall_o(stall)
  );

  always #5 clk = ~clk;

  // Reference extraction using lane part-selects.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [1:0] off, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    h = (off == 2'd2) ? d[31:16] : d[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return d;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every writeback or error pulse.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (wb_valid === 1'b1 && err === 1'b1) begin
        checks++; errors++;
        $display("FAIL pulse_overlap: wb_valid and err both high at %0t", $time);
      end
      if (wb_valid === 1'b1) begin
        checks++;
        if (exp_wb.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected: got rd=%0d data=%h, none expected", wb_rd, wb_data);
        end else begin
          logic [36:0] e;
          e = exp_wb.pop_front();
          if ({wb_rd, wb_data} !== e)
            begin errors++; $display("FAIL wb_value: got rd=%0d data=%h, want rd=%0d data=%h", wb_rd, wb_data, e[36:32], e[31:0]); end
        end
      end
      if (err === 1'b1) begin
        checks++;
        if (exp_err.size() == 0) begin
          errors++;
          $display("FAIL err_unexpected: got cause=%b, none expected", err_cause);
        end else begin
          logic [1:0] c;
          c = exp_err.pop_front();
          if (err_cause !== c)
            begin errors++; $display("FAIL err_cause: got %b want %b", err_cause, c); end
        end
      end
      if (mem_rreq === 1'b1) begin
        checks++;
        if (mem_raddr[1:0] !== 2'b00)
          begin errors++; $display("FAIL raddr_align: got %h want 4-aligned", mem_raddr); end
      end
    end
  end

  // All tasks start and end at #1 after a rising edge.
  task automatic issue(input logic [31:0] a, input logic [2:0] f, input logic [4:0] r);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL req_ready: got %b want 1", req_ready); end
    req_valid = 1'b1; req_addr = a; req_funct3 = f; req_rd = r;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f, input logic [4:0] r,
                         input logic [31:0] d, input logic [31:0] expd, input int dly);
    exp_wb.push_back({r, expd});
    issue(a, f, r);
    checks++;
    if (mem_rreq !== 1'b1 || mem_raddr !== {a[31:2], 2'b00}) begin
      errors++; $display("FAIL rreq: got rreq=%b raddr=%h want 1 %h", mem_rreq, mem_raddr, {a[31:2], 2'b00});
    end
    mem_rdata = d;
    for (int i = 0; i < dly; i++) begin
      @(posedge clk); #1;
      checks++;
      if (stall !== 1'b1 || mem_rreq !== 1'b0) begin
        errors++; $display("FAIL wait_state: got stall=%b rreq=%b want 1 0", stall, mem_rreq);
      end
    end
    mem_rvalid = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL wb_latency: got wb_valid=%b stall=%b want 1 0", wb_valid, stall);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #2;
    checks++;
    if (stall !== 0 || req_ready !== 1 || mem_rreq !== 0 || wb_valid !== 0 || err !== 0 ||
        err_cause !== 2'b00 || mem_raddr !== 32'h0 || wb_data !== 32'h0 || wb_rd !== 5'd0) begin
      errors++; $display("FAIL reset_values: stall=%b rdy=%b rreq=%b wbv=%b err=%b cause=%b raddr=%h wbd=%h wbrd=%0d",
                         stall, req_ready, mem_rreq, wb_valid, err, err_cause, mem_raddr, wb_data, wb_rd);
    end
    @(posedge clk); #2; reset_n = 1'b1;
    @(posedge clk); #1;
    // Reset in the middle of WAIT abandons the load.
    issue(32'h0000_1004, 3'b010, 5'd7);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL reset_pre_wait: got stall=%b want 1", stall); end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (stall !== 0 || req_ready !== 1 || mem_rreq !== 0 || wb_valid !== 0 || err !== 0) begin
      errors++; $display("FAIL reset_mid_wait: stall=%b rdy=%b rreq=%b wbv=%b err=%b want 0 1 0 0 0",
                         stall, req_ready, mem_rreq, wb_valid, err);
    end
    #1; reset_n = 1'b1;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = RDATA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL late_rvalid: got wb_valid=%b stall=%b want 0 0", wb_valid, stall);
    end
  endtask

  task automatic test_extract;
    // Spec reference points.
    do_load(32'h0000_2003, 3'b000, 5'd1, RDATA, 32'hFFFF_FF80, 1);
    do_load(32'h0000_2001, 3'b100, 5'd2, RDATA, 32'h0000_007F, 2);
    do_load(32'h0000_2002, 3'b001, 5'd3, RDATA, 32'hFFFF_80FF, 0);
    do_load(32'h0000_2000, 3'b101, 5'd4, RDATA, 32'h0000_7F01, 1);
    do_load(32'h0000_2000, 3'b010, 5'd5, RDATA, 32'h80FF_7F01, 3);
    // Sweep every load type over every offset.
    for (int t = 0; t < 5; t++) begin
      for (int o = 0; o < 4; o++) begin
        logic [2:0]  f;
        logic [31:0] a;
        logic        mis;
        case (t)
          0: f = 3'b000; 1: f = 3'b100; 2: f = 3'b001; 3: f = 3'b101; default: f = 3'b010;
        endcase
        a = 32'hABCD_0010 + 32'(o);
        mis = ((f == 3'b001 || f == 3'b101) && a[0]) || (f == 3'b010 && a[1:0] != 2'b00);
        if (mis) begin
          exp_err.push_back(2'b01);
          issue(a, f, 5'(8 + o));
          checks++;
          if (err !== 1'b1 || mem_rreq !== 1'b0 || stall !== 1'b0) begin
            errors++; $display("FAIL misalign_sweep f3=%b off=%0d: err=%b rreq=%b stall=%b want 1 0 0", f, o, err, mem_rreq, stall);
          end
        end else begin
          logic [31:0] d;
          d = $urandom();
          do_load(a, f, 5'(8 + o), d, model(f, a[1:0], d), o);
        end
      end
    end
  endtask

  task automatic test_errors;
    exp_err.push_back(2'b01);
    issue(32'h0000_3001, 3'b001, 5'd9);
    checks++;
    if (err !== 1'b1 || mem_rreq !== 1'b0) begin
      errors++; $display("FAIL lh_misalign: err=%b rreq=%b want 1 0", err, mem_rreq);
    end
    exp_err.push_back(2'b10);
    issue(32'h0000_3000, 3'b011, 5'd9);
    checks++;
    if (err !== 1'b1 || mem_rreq !== 1'b0) begin
      errors++; $display("FAIL illegal_f3: err=%b rreq=%b want 1 0", err, mem_rreq);
    end
    // Illegal and misaligned together: illegal wins.
    exp_err.push_back(2'b10);
    issue(32'h0000_3003, 3'b111, 5'd9);
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got err=%b want 0", err); end
  endtask

  task automatic test_back_to_back;
    // Error requests on consecutive edges.
    exp_err.push_back(2'b10);
    exp_err.push_back(2'b01);
    exp_err.push_back(2'b10);
    req_valid = 1'b1; req_addr = 32'h10; req_funct3 = 3'b110; req_rd = 5'd1;
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL b2b_err0: got err=%b want 1", err); end
    req_addr = 32'h12; req_funct3 = 3'b010;
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL b2b_err1: got err=%b want 1", err); end
    req_addr = 32'h10; req_funct3 = 3'b011;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL b2b_err2: got err=%b want 1", err); end
    // Combinational memory: wb 2 cycles after handshake, next request taken in the wb cycle.
    do_load(32'h0000_4000, 3'b010, 5'd11, 32'h1234_5678, 32'h1234_5678, 0);
    do_load(32'h0000_4005, 3'b000, 5'd12, 32'h0000_F000, 32'hFFFF_FFF0, 0);
    do_load(32'h0000_4006, 3'b101, 5'd13, 32'hBEEF_0000, 32'h0000_BEEF, 0);
  endtask

  task automatic test_flush;
    // Flush in WAIT, response 3 cycles later: drained silently.
    issue(32'h0000_5000, 3'b010, 5'd14);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (stall !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL flush_drain: stall=%b rdy=%b want 1 0", stall, req_ready);
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = RDATA;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checks++;
    if (stall !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_discard: stall=%b wbv=%b want 0 0", stall, wb_valid);
    end
    // Flush together with the response: straight back to IDLE.
    issue(32'h0000_5004, 3'b000, 5'd15);
    flush = 1'b1; mem_rvalid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; mem_rvalid = 1'b0;
    checks++;
    if (stall !== 1'b0 || wb_valid !== 1'b0) begin
      errors++; $display("FAIL flush_rvalid: stall=%b wbv=%b want 0 0", stall, wb_valid);
    end
    // Flush in IDLE does not disturb the handshake.
    flush = 1'b1;
    exp_wb.push_back({5'd16, 32'h0000_0080});
    issue(32'h0000_5001, 3'b100, 5'd16);
    flush = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_8000;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    checks++;
    if (wb_valid !== 1'b1) begin errors++; $display("FAIL flush_idle: wbv=%b want 1", wb_valid); end
  endtask

  task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
    exp_err.push_back(2'b11);
    issue(32'h0000_6000, 3'b010, 5'd17);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b0 || stall !== 1'b1) begin
        errors++; $display("FAIL timeout_early cyc%0d: err=%b stall=%b want 0 1", i, err, stall);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL timeout_fire: err=%b stall=%b want 1 0", err, stall);
    end
`else
    logic dropped;
    dropped = 1'b0;
    issue(32'h0000_6000, 3'b010, 5'd17);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (stall !== 1'b1 || err !== 1'b0) dropped = 1'b1;
    end
    checks++;
    if (dropped) begin errors++; $display("FAIL no_timeout: stall dropped or err seen, stall=%b err=%b", stall, err); end
    reset_n = 1'b0;
    #1; reset_n = 1'b1;
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0; req_rd = '0;
    flush = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    test_reset;
    test_extract;
    test_errors;
    test_back_to_back;
    test_flush;
    test_timeout;
    @(posedge clk); #1;
    checks++;
    if (exp_wb.size() != 0 || exp_err.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d wb and %0d err still expected", exp_wb.size(), exp_err.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
